// File: rtl/cnn_frame_scheduler.sv
// Round-robin scheduler sharing one CNN inference engine between NUM_REQ frame sources.
// Optional performance counters are enabled by defining SCHED_PERF_CNT_EN.
module cnn_frame_scheduler #(
    parameter int NUM_REQ        = 2,
    parameter int FRAME_PIXELS   = 1024,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int RESULT_W       = 48
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_grant,
    input  logic [NUM_REQ-1:0]         src_pix_valid,
    input  logic [NUM_REQ*8-1:0]       src_pix_data,
    output logic [NUM_REQ-1:0]         src_pix_ready,
    output logic                       cnn_start,
    output logic                       cnn_pixel_valid,
    output logic [7:0]                 cnn_pixel,
    input  logic                       cnn_busy,
    input  logic                       cnn_result_valid,
    input  logic signed [RESULT_W-1:0] cnn_result,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic signed [RESULT_W-1:0] rsp_data,
    output logic                       rsp_err
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]                perf_frames,
    output logic [15:0]                perf_timeouts,
    output logic [23:0]                perf_last_cycles
`endif
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int PCW = $clog2(FRAME_PIXELS + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES);
    localparam logic [PCW-1:0] PIX_LAST = PCW'(FRAME_PIXELS - 1);
    localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [IDW-1:0] ID_LAST  = IDW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        STREAM,
        WAIT_RES,
        RESP
    } state_t;

    state_t                       state_reg;
    logic [IDW-1:0]               ptr_reg;
    logic [IDW-1:0]               gidx_reg;
    logic [NUM_REQ-1:0]           grant_reg;
    logic [NUM_REQ-1:0]           ready_reg;
    logic                         start_reg;
    logic                         pv_reg;
    logic [7:0]                   pix_reg;
    logic [PCW-1:0]               pix_cnt_reg;
    logic [TCW-1:0]               tmo_cnt_reg;
    logic                         rsp_valid_reg;
    logic [IDW-1:0]               rsp_id_reg;
    logic signed [RESULT_W-1:0]   rsp_data_reg;
    logic                         rsp_err_reg;

    logic [7:0]                   pix_arr [NUM_REQ];
    logic [IDW-1:0]               pick_idx_next;
    logic                         pix_hs;
    logic                         result_take;
    logic                         tmo_hit;
    logic                         rsp_fire;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign pix_arr[gi] = src_pix_data[8*gi +: 8];
        end
    endgenerate

    // Scanning offsets from high to low lets the closest requester after the pointer win.
    function automatic logic [IDW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDW-1:0]     ptr);
        logic [IDW-1:0] sel;
        int             cand;
        sel = ptr;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % NUM_REQ;
            if (req[cand]) begin
                sel = IDW'(cand);
            end
        end
        return sel;
    endfunction

    always_comb begin
        pick_idx_next = rr_pick(req_valid, ptr_reg);
    end

    assign pix_hs      = ready_reg[gidx_reg] & src_pix_valid[gidx_reg];
    assign result_take = (state_reg == WAIT_RES) && cnn_result_valid;
    assign tmo_hit     = (state_reg == WAIT_RES) && !cnn_result_valid && (tmo_cnt_reg == TMO_LAST);
    assign rsp_fire    = (state_reg == RESP) && rsp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            gidx_reg      <= '0;
            grant_reg     <= '0;
            ready_reg     <= '0;
            start_reg     <= 1'b0;
            pv_reg        <= 1'b0;
            pix_reg       <= '0;
            pix_cnt_reg   <= '0;
            tmo_cnt_reg   <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            start_reg <= 1'b0;
            pv_reg    <= pix_hs;
            if (pix_hs) begin
                pix_reg <= pix_arr[gidx_reg];
            end

            case (state_reg)
                IDLE: begin
                    if ((|req_valid) && !cnn_busy) begin
                        gidx_reg  <= pick_idx_next;
                        grant_reg <= NUM_REQ'(1) << pick_idx_next;
                        state_reg <= START;
                    end
                end
                START: begin
                    start_reg   <= 1'b1;
                    ready_reg   <= grant_reg;
                    pix_cnt_reg <= '0;
                    state_reg   <= STREAM;
                end
                STREAM: begin
                    if (pix_hs) begin
                        pix_cnt_reg <= pix_cnt_reg + 1'b1;
                        if (pix_cnt_reg == PIX_LAST) begin
                            ready_reg   <= '0;
                            tmo_cnt_reg <= '0;
                            state_reg   <= WAIT_RES;
                        end
                    end
                end
                WAIT_RES: begin
                    // A result arriving on the final timeout cycle still counts as a result.
                    if (cnn_result_valid) begin
                        rsp_data_reg  <= cnn_result;
                        rsp_err_reg   <= 1'b0;
                        rsp_id_reg    <= gidx_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else if (tmo_cnt_reg == TMO_LAST) begin
                        rsp_data_reg  <= '0;
                        rsp_err_reg   <= 1'b1;
                        rsp_id_reg    <= gidx_reg;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RESP;
                    end else begin
                        tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        grant_reg     <= '0;
                        ptr_reg       <= (gidx_reg == ID_LAST) ? '0 : gidx_reg + 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign req_grant       = grant_reg;
    assign src_pix_ready   = ready_reg;
    assign cnn_start       = start_reg;
    assign cnn_pixel_valid = pv_reg;
    assign cnn_pixel       = pix_reg;
    assign rsp_valid       = rsp_valid_reg;
    assign rsp_id          = rsp_id_reg;
    assign rsp_data        = rsp_data_reg;
    assign rsp_err         = rsp_err_reg;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_frames_reg;
    logic [15:0] perf_timeouts_reg;
    logic [23:0] perf_last_cycles_reg;
    logic [23:0] frame_cyc_reg;

    // frame_cyc_reg reads 0 in the cnn_start cycle, so +1 at the RESP transition gives start-to-RESP distance.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_frames_reg      <= '0;
            perf_timeouts_reg    <= '0;
            perf_last_cycles_reg <= '0;
            frame_cyc_reg        <= '0;
        end else begin
            if (state_reg == START) begin
                frame_cyc_reg <= '0;
            end else if (frame_cyc_reg != '1) begin
                frame_cyc_reg <= frame_cyc_reg + 1'b1;
            end
            if (result_take || tmo_hit) begin
                perf_last_cycles_reg <= (frame_cyc_reg == '1) ? frame_cyc_reg : frame_cyc_reg + 1'b1;
            end
            if (rsp_fire && !rsp_err_reg && (perf_frames_reg != '1)) begin
                perf_frames_reg <= perf_frames_reg + 1'b1;
            end
            if (rsp_fire && rsp_err_reg && (perf_timeouts_reg != '1)) begin
                perf_timeouts_reg <= perf_timeouts_reg + 1'b1;
            end
        end
    end

    assign perf_frames      = perf_frames_reg;
    assign perf_timeouts    = perf_timeouts_reg;
    assign perf_last_cycles = perf_last_cycles_reg;
`else
    logic unused_perf;
    assign unused_perf = result_take ^ tmo_hit ^ rsp_fire;
`endif

endmodule
